// File: rtl/hc_pkg.sv
// Shared healthcare-store definitions: record width, bank ids,
// and the record-store FSM state encoding.
package hc_pkg;

  localparam int REC_DW = 8;

  localparam logic BANK_P = 1'b0;
  localparam logic BANK_Q = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESP  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/record_ring.sv
// One bank of records: DEPTH-entry ring with push/pop/wipe.
// Ports: push/pop (pre-qualified by owner), wipe_en/wipe_idx
// zero one entry, wipe_done resets pointers and count;
// rdata is the head entry, count/full/empty report occupancy.
module record_ring #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int CW    = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  input  logic          wipe_en,
  input  logic [AW-1:0] wipe_idx,
  input  logic          wipe_done,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Storage has no reset; its contents are don't-care
  // until written.
  always_ff @(posedge clock) begin
    if (wipe_en) begin
      mem[wipe_idx] <= '0;
    end else if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // A push into a full ring is only issued alongside a pop,
  // so the head slot is read before it is overwritten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (wipe_done) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/patient_record_store.sv
// Two-bank record store fed by write grants, drained by a
// req/valid read port, wiped by a multi-cycle clear.
// Ports: clock/reset; writeRegP/writeRegQ/data_in append;
// read_req/read_sel/clear commands (sampled in IDLE);
// read_data/read_valid/read_err response; countP/countQ,
// sticky overflow and busy status.
module patient_record_store
  import hc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = REC_DW,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          writeRegP,
  input  logic          writeRegQ,
  input  logic [DW-1:0] data_in,
  input  logic          read_req,
  input  logic          read_sel,
  input  logic          clear,
  output logic [DW-1:0] read_data,
  output logic          read_valid,
  output logic          read_err,
  output logic [CW-1:0] countP,
  output logic [CW-1:0] countQ,
  output logic          overflow,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);

  state_t        state;
  state_t        nstate;
  logic [AW-1:0] clr_idx;

  logic [DW-1:0] rdata_p, rdata_q;
  logic          full_p, full_q;
  logic          empty_p, empty_q;

  logic          in_idle, in_clear;
  logic          rd_go;
  logic          sel_empty;
  logic [DW-1:0] sel_data;
  logic          pop_p, pop_q;
  logic          wr_p, wr_q;
  logic          push_p, push_q;
  logic          drop;
  logic          wipe_done;

  logic          rv_n;
  logic          rerr_n;
  logic [DW-1:0] rdata_n;

  assign in_idle  = (state == S_IDLE);
  assign in_clear = (state == S_CLEAR);
  assign busy     = !in_idle;

  // clear outranks read_req when both arrive in IDLE
  assign rd_go = in_idle && !clear && read_req;

  assign sel_empty =
    (read_sel == BANK_Q) ? empty_q : empty_p;
  assign sel_data =
    (read_sel == BANK_Q) ? rdata_q : rdata_p;

  assign pop_p = rd_go && (read_sel == BANK_P) && !empty_p;
  assign pop_q = rd_go && (read_sel == BANK_Q) && !empty_q;

  assign wr_p = writeRegP && !in_clear;
  assign wr_q = writeRegQ && !in_clear;

  // a full bank still accepts a write when it pops this edge
  assign push_p = wr_p && (!full_p || pop_p);
  assign push_q = wr_q && (!full_q || pop_q);

  assign drop = (wr_p && !push_p) || (wr_q && !push_q);

  assign wipe_done =
    in_clear && (clr_idx == AW'(DEPTH - 1));

  always_comb begin
    nstate  = state;
    rv_n    = 1'b0;
    rerr_n  = 1'b0;
    rdata_n = '0;
    unique case (state)
      S_IDLE: begin
        if (clear) begin
          nstate = S_CLEAR;
        end else if (read_req) begin
          nstate  = S_RESP;
          rv_n    = 1'b1;
          rerr_n  = sel_empty;
          rdata_n = sel_empty ? '0 : sel_data;
        end
      end
      S_RESP:  nstate = S_IDLE;
      S_CLEAR: if (wipe_done) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      clr_idx    <= '0;
      read_valid <= 1'b0;
      read_err   <= 1'b0;
      read_data  <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= nstate;
      clr_idx    <= in_clear ? clr_idx + AW'(1) : '0;
      read_valid <= rv_n;
      read_err   <= rerr_n;
      read_data  <= rdata_n;
      overflow   <= overflow | drop;
    end
  end

  record_ring #(
    .DEPTH(DEPTH), .DW(DW), .CW(CW), .AW(AW)
  ) u_ring_p (
    .clock    (clock),
    .reset    (reset),
    .push     (push_p),
    .pop      (pop_p),
    .wdata    (data_in),
    .wipe_en  (in_clear),
    .wipe_idx (clr_idx),
    .wipe_done(wipe_done),
    .rdata    (rdata_p),
    .count    (countP),
    .full     (full_p),
    .empty    (empty_p)
  );

  record_ring #(
    .DEPTH(DEPTH), .DW(DW), .CW(CW), .AW(AW)
  ) u_ring_q (
    .clock    (clock),
    .reset    (reset),
    .push     (push_q),
    .pop      (pop_q),
    .wdata    (data_in),
    .wipe_en  (in_clear),
    .wipe_idx (clr_idx),
    .wipe_done(wipe_done),
    .rdata    (rdata_q),
    .count    (countQ),
    .full     (full_q),
    .empty    (empty_q)
  );

endmodule
